sc_io_bridge: RTL and testbench
===============================

# sc_io_bridge

Parametrised memory-mapped I/O bridge between the single-cycle CPU data bus and the data memory. It replaces fixed I/O ports with configurable counts of registered output ports and synchronised input ports. It adds per-input change detection, a sticky flag register, an interrupt mask and per-port write strobes. Address decode, memory write gating and read-data muxing all happen here, so the CPU drives one bus and sees one read-data path.

## Interface

- DATA_W, 32, data and port width
- ADDR_W, 32, CPU address width
- N_OUT, 3, number of output ports (1..16)
- N_IN, 2, number of input ports (1..14)
- IO_SEL_BIT, 7, address bit that selects I/O space (1 = I/O, 0 = data memory)

- clock  in  1  system clock; all state updates on the rising edge
- resetn  in  1  asynchronous, active-low reset
- addr  in  ADDR_W  CPU data address (ALU output)
- wdata  in  DATA_W  CPU store data
- we  in  1  CPU store enable
- mem_rdata  in  DATA_W  data memory read data
- mem_we  out  1  data memory write enable
- rdata  out  DATA_W  read data returned to the CPU
- in_port  in  N_IN*DATA_W  asynchronous input ports; port k is bits [k*DATA_W +: DATA_W]
- out_port  out  N_OUT*DATA_W  registered output ports, same packing
- out_strobe  out  N_OUT  one-cycle pulse per port after that port is written
- irq  out  1  level interrupt request

## Operation

- io_sel = addr[IO_SEL_BIT]. Word index i = addr[6:2]. addr[1:0] is ignored.
- mem_we = we & ~io_sel. This path is combinational.
- rdata = io_sel ? io_rdata : mem_rdata. This path is combinational and reads only registered state.
- I/O map by word index i:
  - 0..N_OUT-1: out_port[i], read/write.
  - 16..16+N_IN-1: synchronised in_port[i-16], read-only.
  - 30: irq_mask[N_IN-1:0], read/write.
  - 31: flags[N_IN-1:0], read; writing 1 to a bit clears it.
  - All other indices: read 0, writes ignored. Upper unused bits read 0.
- Output write: on a clock edge with we & io_sel & i<N_OUT:
  - out_port[i] <= wdata.
  - out_strobe[i] is high for exactly the following cycle.
  - Back-to-back writes give a continuous strobe.
- Input path: each port uses a two-flop synchroniser, sync1 then sync2, plus a prev register that holds the last sync2 value.
- Change flag: flags[k] is set on any edge where sync2[k] != prev[k]. The flag is sticky.
- Simultaneous set and write-1-to-clear on the same bit: set wins, and the flag stays 1.
- Writes to read-only words (input ports) have no effect.
- irq = |(flags & irq_mask). It is combinational from registers.
- Reset (resetn=0, asynchronous):
  - All out_port, out_strobe, flags, irq_mask, sync1, sync2 and prev registers go to 0.
  - irq goes to 0.
  - Reset asserted mid-write discards that write.
- After reset release, an in_port that is non-zero sets its flag, because prev starts at 0. This is intended, since software clears flags at init.

## Timing

- Store to an output port: the value appears on out_port at the edge where we=1. out_strobe is high for the next cycle.
- Load from any I/O word: zero-cycle latency. rdata is valid in the same cycle as addr.
- Input change stable before edge t:
  - sync1 captures it at t.
  - sync2 captures it at t+1 and the value becomes readable.
  - The flag sets at edge t+2.
  - irq rises after edge t+2 if the bit is masked in.
- Write-1-to-clear to flags takes effect at the store edge. irq drops in the same cycle if no other flags remain.
- A store and a load never coincide. The single-cycle CPU issues one access per cycle.

## Test plan

- Reset: hold resetn=0 with we=1 at addr 0x80, wdata 0xDEAD -> all out_port=0, out_strobe=0, irq=0, and the write is dropped.
- Output write: store 0x12345678 to addr 0x84 (out_port1) -> out_port1=0x12345678 after the edge, out_strobe=3'b010 for one cycle, mem_we=0; a load from 0x84 returns 0x12345678.
- Memory pass-through: store 0xA5A5A5A5 to addr 0x10 -> mem_we=1 and no out_port changes; a load from 0x10 returns mem_rdata.
- Input sync and flag: drive in_port0=0x55 before edge t -> a load from 0xC0 returns 0x55 from after edge t+1; the status word at 0xFC reads 0x1 after edge t+2. With irq_mask=0x1 (store to 0xF8), irq=1.
- Clear race: store 0x1 to 0xFC on the same edge that in_port0 causes a new change -> flags[0] stays 1 and irq stays 1. A second clear with a stable input -> flags[0]=0, irq=0.
- Unmapped and read-only words: a store to 0xC0 (input word) and to 0xA0 (index 8, unmapped) -> no state changes; a load from 0xA0 returns 0.

Source files
------------

// File: rtl/sc_io_bridge.sv
`timescale 1ns/1ps
// sc_io_bridge: memory-mapped I/O bridge between the CPU data bus and data memory.
// Ports: clock/resetn; addr, wdata, we from the CPU; mem_rdata in / mem_we out to data memory;
// rdata back to the CPU; in_port (async inputs), out_port (registered outputs),
// out_strobe (per-port write pulse), irq (masked sticky change flags).
module sc_io_bridge #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 32,
   parameter int N_OUT      = 3,
   parameter int N_IN       = 2,
   parameter int IO_SEL_BIT = 7
) (
   input  logic                    clock,
   input  logic                    resetn,
   input  logic [ADDR_W-1:0]       addr,
   input  logic [DATA_W-1:0]       wdata,
   input  logic                    we,
   input  logic [DATA_W-1:0]       mem_rdata,
   output logic                    mem_we,
   output logic [DATA_W-1:0]       rdata,
   input  logic [N_IN*DATA_W-1:0]  in_port,
   output logic [N_OUT*DATA_W-1:0] out_port,
   output logic [N_OUT-1:0]        out_strobe,
   output logic                    irq
);

   localparam logic [4:0] IDX_MASK = 5'd30;
   localparam logic [4:0] IDX_FLAG = 5'd31;
   localparam logic [4:0] IDX_IN0  = 5'd16;

   logic             io_sel;
   logic [4:0]       idx;
   logic             io_wr;
   logic             unused_addr;

   logic [DATA_W-1:0] out_q  [N_OUT];
   logic [N_OUT-1:0]  out_hit;
   logic [N_OUT-1:0]  strobe_q;

   logic [DATA_W-1:0] in_w   [N_IN];
   logic [DATA_W-1:0] sync1  [N_IN];
   logic [DATA_W-1:0] sync2  [N_IN];
   logic [DATA_W-1:0] prev   [N_IN];

   logic [N_IN-1:0]   chg;
   logic [N_IN-1:0]   clr;
   logic [N_IN-1:0]   flags;
   logic [N_IN-1:0]   irq_mask;
   logic              mask_wr;

   logic [DATA_W-1:0] io_rdata;

   // Only the select bit and the word index matter; the rest is decoded elsewhere.
   assign unused_addr = ^addr;

   assign io_sel  = addr[IO_SEL_BIT];
   assign idx     = addr[6:2];
   assign io_wr   = we & io_sel;
   assign mem_we  = we & ~io_sel;
   assign mask_wr = io_wr & (idx == IDX_MASK);

   // Port packing / unpacking.
   for (genvar k = 0; k < N_OUT; k++) begin : g_out
      assign out_hit[k] = io_wr & (idx == 5'(k));
      assign out_port[k*DATA_W +: DATA_W] = out_q[k];
   end

   for (genvar k = 0; k < N_IN; k++) begin : g_in
      assign in_w[k] = in_port[k*DATA_W +: DATA_W];
      assign chg[k]  = |(sync2[k] ^ prev[k]);
   end

   // Write-1-to-clear only applies to a store aimed at the flag word.
   assign clr = (io_wr & (idx == IDX_FLAG)) ? wdata[N_IN-1:0] : '0;

   // Output ports and their one-cycle strobes.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         for (int k = 0; k < N_OUT; k++) out_q[k] <= '0;
         strobe_q <= '0;
      end else begin
         for (int k = 0; k < N_OUT; k++)
            if (out_hit[k]) out_q[k] <= wdata;
         strobe_q <= out_hit;
      end
   end

   assign out_strobe = strobe_q;

   // Two-flop synchroniser plus a history register for edge detection.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         for (int k = 0; k < N_IN; k++) begin
            sync1[k] <= '0;
            sync2[k] <= '0;
            prev[k]  <= '0;
         end
      end else begin
         for (int k = 0; k < N_IN; k++) begin
            sync1[k] <= in_w[k];
            sync2[k] <= sync1[k];
            prev[k]  <= sync2[k];
         end
      end
   end

   // Sticky flags: a new change on the same edge as a clear keeps the flag set.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         flags    <= '0;
         irq_mask <= '0;
      end else begin
         flags <= (flags & ~clr) | chg;
         if (mask_wr) irq_mask <= wdata[N_IN-1:0];
      end
   end

   assign irq = |(flags & irq_mask);

   // Read mux sees only registered state, so loads have zero latency.
   always_comb begin
      io_rdata = '0;
      for (int k = 0; k < N_OUT; k++)
         if (idx == 5'(k)) io_rdata = out_q[k];
      for (int k = 0; k < N_IN; k++)
         if (idx == IDX_IN0 + 5'(k)) io_rdata = sync2[k];
      if (idx == IDX_MASK) io_rdata[N_IN-1:0] = irq_mask;
      if (idx == IDX_FLAG) io_rdata[N_IN-1:0] = flags;
   end

   assign rdata = io_sel ? io_rdata : mem_rdata;

endmodule

// File: tb/tb_sc_io_bridge.sv
`timescale 1ns/1ps
// tb_sc_io_bridge: directed self-checking bench for sc_io_bridge.
// Drives stimulus #1 after rising edges and checks outputs before the next edge.
module tb_sc_io_bridge;

   logic        clock = 0;
   logic        resetn;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        we;
   logic [31:0] mem_rdata;
   logic        mem_we;
   logic [31:0] rdata;
   logic [63:0] in_port;
   logic [95:0] out_port;
   logic [2:0]  out_strobe;
   logic        irq;

   int n_chk  = 0;
   int n_pass = 0;
   logic [95:0] exp_out;

   sc_io_bridge dut (
      .clock(clock), .resetn(resetn), .addr(addr), .wdata(wdata),
      .we(we), .mem_rdata(mem_rdata), .mem_we(mem_we), .rdata(rdata),
      .in_port(in_port), .out_port(out_port), .out_strobe(out_strobe),
      .irq(irq)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      resetn = 0; we = 1; addr = 32'h80; wdata = 32'hDEAD;
      mem_rdata = 32'h0; in_port = '0;
      tick(); tick();
      n_chk++;
      if (out_port !== 96'h0) $display("FAIL rst_out: got %h want 0", out_port);
      else n_pass++;
      n_chk++;
      if (out_strobe !== 3'b000) $display("FAIL rst_strobe: got %b want 000", out_strobe);
      else n_pass++;
      n_chk++;
      if (irq !== 1'b0) $display("FAIL rst_irq: got %b want 0", irq);
      else n_pass++;
      n_chk++;
      if (mem_we !== 1'b0) $display("FAIL rst_memwe: got %b want 0", mem_we);
      else n_pass++;
      we = 0;
      #1 resetn = 1;
      tick();
      n_chk++;
      if (out_port !== 96'h0) $display("FAIL rst_dropped: got %h want 0", out_port);
      else n_pass++;
      exp_out = '0;
   endtask

   task automatic test_out_write();
      addr = 32'h84; wdata = 32'h12345678; we = 1;
      #1;
      n_chk++;
      if (mem_we !== 1'b0) $display("FAIL ow_memwe: got %b want 0", mem_we);
      else n_pass++;
      tick();
      we = 0;
      exp_out[63:32] = 32'h12345678;
      n_chk++;
      if (out_port !== exp_out) $display("FAIL ow_out: got %h want %h", out_port, exp_out);
      else n_pass++;
      n_chk++;
      if (out_strobe !== 3'b010) $display("FAIL ow_strobe: got %b want 010", out_strobe);
      else n_pass++;
      #1;
      n_chk++;
      if (rdata !== 32'h12345678) $display("FAIL ow_read: got %h want 12345678", rdata);
      else n_pass++;
      tick();
      n_chk++;
      if (out_strobe !== 3'b000) $display("FAIL ow_strobe_end: got %b want 000", out_strobe);
      else n_pass++;
   endtask

   task automatic test_mem_pass();
      addr = 32'h10; wdata = 32'hA5A5A5A5; we = 1; mem_rdata = 32'hCAFEBABE;
      #1;
      n_chk++;
      if (mem_we !== 1'b1) $display("FAIL mem_we: got %b want 1", mem_we);
      else n_pass++;
      n_chk++;
      if (rdata !== 32'hCAFEBABE) $display("FAIL mem_read: got %h want cafebabe", rdata);
      else n_pass++;
      tick();
      we = 0;
      n_chk++;
      if (out_port !== exp_out) $display("FAIL mem_noout: got %h want %h", out_port, exp_out);
      else n_pass++;
      n_chk++;
      if (out_strobe !== 3'b000) $display("FAIL mem_nostrobe: got %b want 000", out_strobe);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      addr = 32'h80; wdata = 32'h11; we = 1;
      tick();
      n_chk++;
      if (out_strobe !== 3'b001) $display("FAIL b2b_s1: got %b want 001", out_strobe);
      else n_pass++;
      wdata = 32'h33;
      tick();
      exp_out[31:0] = 32'h33;
      n_chk++;
      if (out_strobe !== 3'b001) $display("FAIL b2b_s2: got %b want 001", out_strobe);
      else n_pass++;
      addr = 32'h88; wdata = 32'h22;
      tick();
      we = 0;
      exp_out[95:64] = 32'h22;
      n_chk++;
      if (out_strobe !== 3'b100) $display("FAIL b2b_s3: got %b want 100", out_strobe);
      else n_pass++;
      n_chk++;
      if (out_port !== exp_out) $display("FAIL b2b_out: got %h want %h", out_port, exp_out);
      else n_pass++;
      tick();
      n_chk++;
      if (out_strobe !== 3'b000) $display("FAIL b2b_idle: got %b want 000", out_strobe);
      else n_pass++;
   endtask

   task automatic test_input();
      in_port[31:0] = 32'h55;
      addr = 32'hC0;
      tick();
      n_chk++;
      if (rdata !== 32'h0) $display("FAIL in_t: got %h want 0", rdata);
      else n_pass++;
      tick();
      n_chk++;
      if (rdata !== 32'h55) $display("FAIL in_t1: got %h want 55", rdata);
      else n_pass++;
      addr = 32'hFC;
      #1;
      n_chk++;
      if (rdata !== 32'h0) $display("FAIL flag_t1: got %h want 0", rdata);
      else n_pass++;
      tick();
      n_chk++;
      if (rdata !== 32'h1) $display("FAIL flag_t2: got %h want 1", rdata);
      else n_pass++;
      n_chk++;
      if (irq !== 1'b0) $display("FAIL irq_nomask: got %b want 0", irq);
      else n_pass++;
      addr = 32'hF8; wdata = 32'h1; we = 1;
      tick();
      we = 0;
      n_chk++;
      if (irq !== 1'b1) $display("FAIL irq_mask: got %b want 1", irq);
      else n_pass++;
      n_chk++;
      if (rdata !== 32'h1) $display("FAIL mask_read: got %h want 1", rdata);
      else n_pass++;
   endtask

   task automatic test_clear_race();
      in_port[31:0] = 32'hAA;
      tick();
      tick();
      addr = 32'hFC; wdata = 32'h1; we = 1;
      tick();
      we = 0;
      #1;
      n_chk++;
      if (rdata !== 32'h1) $display("FAIL race_flag: got %h want 1", rdata);
      else n_pass++;
      n_chk++;
      if (irq !== 1'b1) $display("FAIL race_irq: got %b want 1", irq);
      else n_pass++;
      we = 1;
      tick();
      we = 0;
      #1;
      n_chk++;
      if (rdata !== 32'h0) $display("FAIL clr_flag: got %h want 0", rdata);
      else n_pass++;
      n_chk++;
      if (irq !== 1'b0) $display("FAIL clr_irq: got %b want 0", irq);
      else n_pass++;
      in_port[63:32] = 32'h1;
      tick(); tick(); tick();
      n_chk++;
      if (rdata !== 32'h2) $display("FAIL flag1: got %h want 2", rdata);
      else n_pass++;
      n_chk++;
      if (irq !== 1'b0) $display("FAIL irq_unmasked1: got %b want 0", irq);
      else n_pass++;
      wdata = 32'h2; we = 1;
      tick();
      we = 0;
      #1;
      n_chk++;
      if (rdata !== 32'h0) $display("FAIL clr_flag1: got %h want 0", rdata);
      else n_pass++;
   endtask

   task automatic test_unmapped();
      addr = 32'hC0; wdata = 32'hFFFF; we = 1;
      #1;
      n_chk++;
      if (mem_we !== 1'b0) $display("FAIL ro_memwe: got %b want 0", mem_we);
      else n_pass++;
      tick();
      addr = 32'hA0; wdata = 32'h1234;
      tick();
      addr = 32'h8C;
      tick();
      we = 0;
      n_chk++;
      if (out_port !== exp_out) $display("FAIL unm_out: got %h want %h", out_port, exp_out);
      else n_pass++;
      n_chk++;
      if (out_strobe !== 3'b000) $display("FAIL unm_strobe: got %b want 000", out_strobe);
      else n_pass++;
      n_chk++;
      if (rdata !== 32'h0) $display("FAIL rd_idx3: got %h want 0", rdata);
      else n_pass++;
      addr = 32'hA0;
      #1;
      n_chk++;
      if (rdata !== 32'h0) $display("FAIL rd_idx8: got %h want 0", rdata);
      else n_pass++;
      addr = 32'hC0;
      #1;
      n_chk++;
      if (rdata !== 32'hAA) $display("FAIL ro_in0: got %h want aa", rdata);
      else n_pass++;
      addr = 32'hC4;
      #1;
      n_chk++;
      if (rdata !== 32'h1) $display("FAIL ro_in1: got %h want 1", rdata);
      else n_pass++;
      addr = 32'hFC;
      #1;
      n_chk++;
      if (rdata !== 32'h0) $display("FAIL unm_flags: got %h want 0", rdata);
      else n_pass++;
   endtask

   task automatic test_async_reset();
      in_port[31:0] = 32'h77;
      tick(); tick(); tick();
      #1;
      n_chk++;
      if (irq !== 1'b1) $display("FAIL pre_rst_irq: got %b want 1", irq);
      else n_pass++;
      #1 resetn = 0;
      #1;
      n_chk++;
      if (out_port !== 96'h0) $display("FAIL arst_out: got %h want 0", out_port);
      else n_pass++;
      n_chk++;
      if (irq !== 1'b0) $display("FAIL arst_irq: got %b want 0", irq);
      else n_pass++;
      addr = 32'hF8;
      #1;
      n_chk++;
      if (rdata !== 32'h0) $display("FAIL arst_mask: got %h want 0", rdata);
      else n_pass++;
      addr = 32'hC0;
      #1;
      n_chk++;
      if (rdata !== 32'h0) $display("FAIL arst_sync: got %h want 0", rdata);
      else n_pass++;
      resetn = 1;
      tick();
   endtask

   initial begin
      test_reset();
      test_out_write();
      test_mem_pass();
      test_back_to_back();
      test_input();
      test_clear_race();
      test_unmapped();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
